// File: rtl/systolic_ws_ctrl_pkg.sv
// Shared types and constants for the weight-stationary array sequencer.
// Holds the sequencer state encoding, the PE datapath widths and an address-width helper.
package systolic_ws_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  localparam int ACT_W = 8;
  localparam int ACC_W = 32;
  localparam int WGT_W = 8;

  // Bits needed to index n entries (0..n-1); never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_ws_ctrl_if.sv
// Command and array/buffer strobe bundle of the weight-stationary sequencer.
// The master side issues tiles; the slave side is the sequencer itself.
interface systolic_ws_ctrl_if
  import systolic_ws_ctrl_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int CNT_W = 16
) ();

  logic                      start;
  logic                      reuse_weights;
  logic [CNT_W-1:0]          num_vectors;
  logic                      busy;
  logic                      done;
  logic                      w_rd_en;
  logic [addr_w(ROWS)-1:0]   w_rd_addr;
  logic                      act_rd_en;
  logic [CNT_W-1:0]          act_rd_addr;
  logic                      pe_en;
  logic                      pe_w_en;
  logic                      out_valid;
  logic [CNT_W-1:0]          out_addr;

  modport master (
    output start, reuse_weights, num_vectors,
    input  busy, done, w_rd_en, w_rd_addr, act_rd_en, act_rd_addr,
    input  pe_en, pe_w_en, out_valid, out_addr
  );

  modport slave (
    input  start, reuse_weights, num_vectors,
    output busy, done, w_rd_en, w_rd_addr, act_rd_en, act_rd_addr,
    output pe_en, pe_w_en, out_valid, out_addr
  );

endinterface

// File: rtl/systolic_ws_ctrl_delay_line.sv
// Resettable fixed-depth shift register used to align strobes with buffer and array latency.
// data_pre exposes the value data_out will take on the next clock.
module ctrl_delay_line
  import systolic_ws_ctrl_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_pre
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge CLK) begin
          if (RESET) stage_reg[gi] <= '0;
          else       stage_reg[gi] <= data_in;
        end
      end else begin : g_tail
        always_ff @(posedge CLK) begin
          if (RESET) stage_reg[gi] <= '0;
          else       stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end

    if (DEPTH == 1) begin : g_pre_direct
      assign data_pre = data_in;
    end else begin : g_pre_tap
      assign data_pre = stage_reg[DEPTH-2];
    end
  endgenerate

  assign data_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_ws_ctrl.sv
// Tile sequencer for a weight-stationary PE array: weight shift-in, activation streaming,
// pipeline drain and per-row result flagging, one tile per accepted start.
module systolic_ws_ctrl
  import systolic_ws_ctrl_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int CNT_W    = 16,
  parameter int MEM_LAT  = 1,
  parameter int PIPE_LAT = ROWS + COLS - 1
) (
  input logic               CLK,
  input logic               RESET,
  systolic_ws_ctrl_if.slave bus
);

  localparam int W_ADDR_W  = addr_w(ROWS);
  localparam int DRAIN_LEN = MEM_LAT + PIPE_LAT;
  localparam int DRN_W     = addr_w(DRAIN_LEN);

  localparam logic [W_ADDR_W-1:0] W_ADDR_TOP = W_ADDR_W'(ROWS - 1);
  localparam logic [DRN_W-1:0]    DRN_FULL   = DRN_W'(DRAIN_LEN - 1);
  localparam logic [DRN_W-1:0]    DRN_WGT    = DRN_W'(MEM_LAT - 1);

  ctrl_state_e         state_reg;
  logic [CNT_W-1:0]    m_reg;
  logic                w_rd_en_reg;
  logic [W_ADDR_W-1:0] w_rd_addr_reg;
  logic                act_rd_en_reg;
  logic [CNT_W-1:0]    act_rd_addr_reg;
  logic [DRN_W-1:0]    drain_cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                pe_en_reg;

  logic [CNT_W+1:0]    align_out;
  logic [CNT_W+1:0]    align_pre;
  logic [CNT_W:0]      pipe_out;
  logic [CNT_W:0]      pipe_pre_unused;
  logic [CNT_W-1:0]    align_pre_addr_unused;

  logic                pe_w_pre;
  logic                act_pre;
  logic                act_vld;
  logic [CNT_W-1:0]    act_addr;

  assign pe_w_pre              = align_pre[CNT_W+1];
  assign act_pre               = align_pre[CNT_W];
  assign align_pre_addr_unused = align_pre[CNT_W-1:0];
  assign act_vld               = align_out[CNT_W];
  assign act_addr              = align_out[CNT_W-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg       <= ST_IDLE;
      m_reg           <= '0;
      w_rd_en_reg     <= 1'b0;
      w_rd_addr_reg   <= '0;
      act_rd_en_reg   <= 1'b0;
      act_rd_addr_reg <= '0;
      drain_cnt_reg   <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      pe_en_reg       <= 1'b0;
    end else begin
      // Array enable latches on at the first data arrival and holds until the tile ends.
      pe_en_reg <= pe_en_reg | pe_w_pre | act_pre;
      case (state_reg)
        ST_IDLE: begin
          pe_en_reg <= 1'b0;
          if (bus.start) begin
            m_reg    <= bus.num_vectors;
            busy_reg <= 1'b1;
            if (!bus.reuse_weights) begin
              state_reg     <= ST_LOAD_W;
              w_rd_en_reg   <= 1'b1;
              w_rd_addr_reg <= W_ADDR_TOP;
            end else if (bus.num_vectors != '0) begin
              state_reg       <= ST_COMPUTE;
              act_rd_en_reg   <= 1'b1;
              act_rd_addr_reg <= '0;
            end else begin
              state_reg     <= ST_DRAIN;
              drain_cnt_reg <= '0;
            end
          end
        end

        ST_LOAD_W: begin
          if (w_rd_addr_reg == '0) begin
            w_rd_en_reg <= 1'b0;
            if (m_reg != '0) begin
              state_reg       <= ST_COMPUTE;
              act_rd_en_reg   <= 1'b1;
              act_rd_addr_reg <= '0;
            end else begin
              // No activations: only wait for the last weight row to reach the array.
              state_reg     <= ST_DRAIN;
              drain_cnt_reg <= DRN_WGT;
            end
          end else begin
            w_rd_addr_reg <= w_rd_addr_reg - W_ADDR_W'(1);
          end
        end

        ST_COMPUTE: begin
          if (act_rd_addr_reg == m_reg - CNT_W'(1)) begin
            state_reg       <= ST_DRAIN;
            act_rd_en_reg   <= 1'b0;
            act_rd_addr_reg <= '0;
            drain_cnt_reg   <= DRN_FULL;
          end else begin
            act_rd_addr_reg <= act_rd_addr_reg + CNT_W'(1);
          end
        end

        ST_DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            pe_en_reg <= 1'b0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - DRN_W'(1);
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          pe_en_reg <= 1'b0;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Buffer read latency: strobes and address line up with data at the array input.
  ctrl_delay_line #(
    .DEPTH (MEM_LAT),
    .WIDTH (CNT_W + 2)
  ) u_mem_align (
    .CLK      (CLK),
    .RESET    (RESET),
    .data_in  ({w_rd_en_reg, act_rd_en_reg, act_rd_addr_reg}),
    .data_out (align_out),
    .data_pre (align_pre)
  );

  // Array plus skew/deskew latency from array input to output-buffer write port.
  ctrl_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (CNT_W + 1)
  ) u_pipe_align (
    .CLK      (CLK),
    .RESET    (RESET),
    .data_in  ({act_vld, act_addr}),
    .data_out (pipe_out),
    .data_pre (pipe_pre_unused)
  );

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.w_rd_en     = w_rd_en_reg;
  assign bus.w_rd_addr   = w_rd_addr_reg;
  assign bus.act_rd_en   = act_rd_en_reg;
  assign bus.act_rd_addr = act_rd_addr_reg;
  assign bus.pe_en       = pe_en_reg;
  assign bus.pe_w_en     = align_out[CNT_W+1];
  assign bus.out_valid   = pipe_out[CNT_W];
  assign bus.out_addr    = pipe_out[CNT_W-1:0];

endmodule

// File: tb/tb_systolic_ws_ctrl.sv
// Directed bench for systolic_ws_ctrl with a 4x4 array, MEM_LAT=1 and 4-bit counters.
// Each tile is a table row of hand-computed event cycles, checked cycle by cycle.
module tb_systolic_ws_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  systolic_ws_ctrl_if #(.ROWS(ROWS), .CNT_W(CNT_W)) bus ();

  systolic_ws_ctrl #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .CNT_W   (CNT_W),
    .MEM_LAT (1)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Cycle numbers are relative to the cycle in which start is driven (cycle 0).
  typedef struct {
    string name;
    bit    reuse;
    int    m;
    int    w_first;
    int    act_first;
    int    ov_first;
    int    done_cyc;
    bit    spurious;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input int c, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
  endtask

  task automatic check_idle(input string tag, input int c);
    chk({tag, ".busy"},        c, int'(bus.busy), 0);
    chk({tag, ".done"},        c, int'(bus.done), 0);
    chk({tag, ".w_rd_en"},     c, int'(bus.w_rd_en), 0);
    chk({tag, ".w_rd_addr"},   c, int'(bus.w_rd_addr), 0);
    chk({tag, ".act_rd_en"},   c, int'(bus.act_rd_en), 0);
    chk({tag, ".act_rd_addr"}, c, int'(bus.act_rd_addr), 0);
    chk({tag, ".pe_en"},       c, int'(bus.pe_en), 0);
    chk({tag, ".pe_w_en"},     c, int'(bus.pe_w_en), 0);
    chk({tag, ".out_valid"},   c, int'(bus.out_valid), 0);
    chk({tag, ".out_addr"},    c, int'(bus.out_addr), 0);
  endtask

  task automatic check_cycle(input vec_t v, input int c);
    bit ld;
    bit e_w, e_pw, e_a, e_ov, e_pe;
    int fa;
    ld   = !v.reuse;
    e_w  = ld && c >= v.w_first && c < v.w_first + ROWS;
    e_pw = ld && c >= v.w_first + 1 && c <= v.w_first + ROWS;
    e_a  = v.m > 0 && c >= v.act_first && c < v.act_first + v.m;
    e_ov = v.m > 0 && c >= v.ov_first && c < v.ov_first + v.m;
    fa   = ld ? v.w_first + 1 : (v.m > 0 ? v.act_first + 1 : 0);
    e_pe = fa > 0 && c >= fa && c < v.done_cyc;
    chk({v.name, ".busy"},      c, int'(bus.busy), int'(c >= 1 && c <= v.done_cyc));
    chk({v.name, ".done"},      c, int'(bus.done), int'(c == v.done_cyc));
    chk({v.name, ".w_rd_en"},   c, int'(bus.w_rd_en), int'(e_w));
    chk({v.name, ".pe_w_en"},   c, int'(bus.pe_w_en), int'(e_pw));
    chk({v.name, ".act_rd_en"}, c, int'(bus.act_rd_en), int'(e_a));
    chk({v.name, ".out_valid"}, c, int'(bus.out_valid), int'(e_ov));
    chk({v.name, ".pe_en"},     c, int'(bus.pe_en), int'(e_pe));
    if (e_w)  chk({v.name, ".w_rd_addr"},   c, int'(bus.w_rd_addr), ROWS - 1 - (c - v.w_first));
    if (e_a)  chk({v.name, ".act_rd_addr"}, c, int'(bus.act_rd_addr), c - v.act_first);
    if (e_ov) chk({v.name, ".out_addr"},    c, int'(bus.out_addr), c - v.ov_first);
  endtask

  // Entered one step after a rising edge; returns in the cycle after done.
  task automatic run_tile(input vec_t v);
    int errs0;
    errs0 = n_total - n_pass;
    bus.start         = 1'b1;
    bus.reuse_weights = v.reuse;
    bus.num_vectors   = CNT_W'(v.m);
    for (int c = 0; c <= v.done_cyc; c++) begin
      check_cycle(v, c);
      @(posedge CLK);
      #1;
      if (v.spurious && (c + 1 == 3 || c + 1 == 10)) begin
        bus.start         = 1'b1;
        bus.reuse_weights = 1'b1;
        bus.num_vectors   = CNT_W'(7);
      end else begin
        bus.start         = 1'b0;
        bus.reuse_weights = v.reuse;
        bus.num_vectors   = CNT_W'(v.m);
      end
    end
    $display("tile %-12s reuse=%0d m=%0d done_cycle=%0d new_errors=%0d",
             v.name, v.reuse, v.m, v.done_cyc, (n_total - n_pass) - errs0);
  endtask

  initial begin
    //          name          reuse m   w_first act_first ov_first done spurious
    vecs[0] = '{"ld_m3",      1'b0, 3,  1,      5,        13,      16,  1'b0};
    vecs[1] = '{"reuse_m3",   1'b1, 3,  0,      1,        9,       12,  1'b0};
    vecs[2] = '{"ld_m0",      1'b0, 0,  1,      0,        0,       6,   1'b0};
    vecs[3] = '{"reuse_m0",   1'b1, 0,  0,      0,        0,       2,   1'b0};
    vecs[4] = '{"ld_m15",     1'b0, 15, 1,      5,        13,      28,  1'b0};
    vecs[5] = '{"reuse_m15",  1'b1, 15, 0,      1,        9,       24,  1'b0};
    vecs[6] = '{"ld_m3_spur", 1'b0, 3,  1,      5,        13,      16,  1'b1};

    bus.start         = 1'b0;
    bus.reuse_weights = 1'b0;
    bus.num_vectors   = '0;
    RESET             = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_idle("reset", 0);
    RESET = 1'b0;

    // Table tiles run back to back: each start lands the cycle after the previous done.
    for (int i = 0; i < 7; i++) run_tile(vecs[i]);

    // Abort a tile with RESET in cycle 6, then run a fresh tile starting in cycle 8.
    bus.start         = 1'b1;
    bus.reuse_weights = 1'b0;
    bus.num_vectors   = CNT_W'(3);
    for (int c = 1; c <= 6; c++) begin
      @(posedge CLK);
      #1;
      bus.start = 1'b0;
    end
    chk("rst_mid.act_rd_en", 6, int'(bus.act_rd_en), 1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    check_idle("rst_abort", 7);
    @(posedge CLK);
    #1;
    run_tile(vecs[0]);
    check_idle("final", 17);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
